// File: rtl/seg_pkg.sv
// Segment glyph constants shared by the scanner and its glyph ROM.
// Encoding is active-low, bit6=g .. bit0=a.
// Pure constants; no logic, no latency, no flow control.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_glyph_rom.sv
// Nibble to active-low seven-segment glyph; 10..15 blank unless hex_mode.
// Latency: purely combinational.
// Backpressure: none.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_GLYPH[nibble];
        if (nibble >= 4'd10 && !hex_mode) seg = SEG_BLANK;
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous value update.
// Latency: seg/an registered, one cycle behind scan state. Optional SEG_LEADING_ZERO_BLANK_EN.
// Backpressure: none; load is a fire-and-forget strobe, last load in a frame wins.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    hex_mode,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;

    logic                    slot_end;
    logic                    boundary;
    logic                    deadtime;
    logic [3:0]              nib;
    logic                    dig_on;
    logic                    lead_blank;
    logic [NUM_DIGITS-1:0]   lz;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic [6:0]              rom_seg;

    assign slot_end = (presc == CW'(SCAN_DIV - 1));
    assign boundary = slot_end && (idx == IW'(NUM_DIGITS - 1));
    assign deadtime = (presc == '0);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // lz[k]: nibble k and everything above it are zero; digit 0 is never blanked
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (active[4*k +: 4] == 4'd0);
            lz[k]      = zero_above;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib        = '0;
        dig_on     = 1'b0;
        lead_blank = 1'b0;
        an_nxt     = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib        = active[4*k +: 4];
                dig_on     = digit_en[k];
                lead_blank = lz[k];
                an_nxt[k]  = 1'b0;
            end
        end
        if (deadtime) an_nxt = '1;
    end

    seg_glyph_rom u_rom (
        .nibble   (nib),
        .hex_mode (hex_mode),
        .seg      (rom_seg)
    );

    always_comb begin
        seg_nxt = rom_seg;
        if (deadtime || !dig_on || lead_blank) seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + CW'(1);
            if (slot_end) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);

            if (load) shadow <= value;
            // Commit uses the shadow from before this edge; a boundary load waits a frame
            if (boundary) begin
                if (pending) active <= shadow;
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end

            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner at NUM_DIGITS=4, SCAN_DIV=4: vector table, corner sequences, random run.
// Reference model derives scan position from elapsed cycles since reset.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int D = 4;
    localparam int F = N * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        hex_mode = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = 4'hF;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    int          m_t = 0;
    int          last_t = -1;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;
    logic        m_pending = 1'b0;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd;

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .hex_mode   (hex_mode),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] glyph(logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(int t, logic [15:0] act, logic [3:0] en, logic hm);
        int pos;
        int dig;
        logic [3:0] n;
        pos = t % D;
        dig = (t / D) % N;
        n   = 4'((act >> (4 * dig)) & 16'hF);
        if (pos == 0) return 7'h7F;
        if (!en[dig]) return 7'h7F;
        if (n >= 4'd10 && !hm) return 7'h7F;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (act >> (4 * dig)) == 16'd0) return 7'h7F;
`endif
        return glyph(n);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, last_t, act, exp);
        end
    endtask

    // One clock: predict outputs for this edge, advance the model, compare #1 later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            last_t    = -1;
            e_seg     = 7'h7F;
            e_an      = 4'hF;
            e_fd      = 1'b0;
            m_t       = 0;
            m_shadow  = '0;
            m_active  = '0;
            m_pending = 1'b0;
        end else begin
            last_t = m_t;
            e_seg  = model_seg(m_t, m_active, digit_en, hex_mode);
            e_an   = (m_t % D == 0) ? 4'hF : ~(4'b0001 << ((m_t / D) % N));
            e_fd   = (m_t % F == F - 1);
            if (e_fd) begin
                if (m_pending) m_active = m_shadow;
                m_pending = load;
            end else if (load) begin
                m_pending = 1'b1;
            end
            if (load) m_shadow = value;
            m_t++;
        end
        #1;
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("an", {28'd0, an}, {28'd0, e_an});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic goto_t(int t);
        for (int g = 0; g < 200 && m_t < t; g++) tick();
        if (m_t != t) chk("goto_timeout", m_t, t);
    endtask

    task automatic load_once(logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    typedef struct {
        logic [15:0]      v;
        logic             hm;
        logic [3:0]       en;
        logic [3:0][6:0]  exp;
    } vec_t;

    localparam logic [6:0] LZ = 
`ifdef SEG_LEADING_ZERO_BLANK_EN
        7'h7F;
`else
        7'h40;
`endif

    vec_t vecs [6];
    int   fd_times [$];

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 4'hF, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'hABCF, 1'b1, 4'hF, {7'h08, 7'h03, 7'h46, 7'h0E}};
        vecs[2] = '{16'hABCF, 1'b0, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[3] = '{16'h0007, 1'b0, 4'hF, {LZ, LZ, LZ, 7'h78}};
        vecs[4] = '{16'h9999, 1'b0, 4'hB, {7'h10, 7'h7F, 7'h10, 7'h10}};
        vecs[5] = '{16'h0000, 1'b1, 4'hF, {LZ, LZ, LZ, 7'h40}};

        // Reset state
        do_reset();
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);

        // Table: load, wait for first boundary commit, inspect second frame mid-slot
        foreach (vecs[i]) begin
            hex_mode = vecs[i].hm;
            digit_en = 4'hF;
            do_reset();
            load_once(vecs[i].v);
            digit_en = vecs[i].en;
            for (int c = 0; c < 31; c++) begin
                tick();
                if (last_t >= F && last_t % D == 2)
                    chk($sformatf("vec%0d_dig%0d", i, (last_t / D) % N),
                        {25'd0, seg}, {25'd0, vecs[i].exp[(last_t / D) % N]});
            end
        end

        // Mid-frame load: current frame keeps old value, frame_done every 16 cycles
        hex_mode = 1'b0;
        digit_en = 4'hF;
        do_reset();
        load_once(16'h1234);
        goto_t(21);
        load_once(16'h5678);
        fd_times.delete();
        for (int c = 0; c < 40; c++) begin
            tick();
            if (frame_done) fd_times.push_back(last_t);
            if (last_t == 26) chk("midload_old_dig2", {25'd0, seg}, 32'h24);
            if (last_t == 34) chk("midload_new_dig0", {25'd0, seg}, 32'h00);
            if (last_t == 38) chk("midload_new_dig1", {25'd0, seg}, 32'h78);
        end
        if (fd_times.size() < 2) chk("fd_count", fd_times.size(), 2);
        for (int k = 1; k < fd_times.size(); k++)
            chk("fd_period", fd_times[k] - fd_times[k-1], F);

        // Load on the exact boundary cycle commits one frame late
        do_reset();
        load_once(16'h1234);
        goto_t(F - 1);
        load_once(16'h9999);
        goto_t(18);
        tick();
        chk("bndload_still_old", {25'd0, seg}, 32'h19);
        goto_t(34);
        tick();
        chk("bndload_committed", {25'd0, seg}, 32'h10);

        // Reset mid-slot with pending load discards it
        goto_t(41);
        load_once(16'h4321);
        rst_n = 1'b0;
        tick();
        chk("midrst_seg", {25'd0, seg}, 32'h7F);
        chk("midrst_an", {28'd0, an}, 32'hF);
        chk("midrst_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        goto_t(2);
        tick();
        chk("postrst_dig0", {25'd0, seg}, 32'h40);
        goto_t(F + 6);
        tick();
        chk("postrst_dig1", {25'd0, seg}, {25'd0, LZ});

        // Randomized run against the model
        for (int c = 0; c < 2500; c++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) hex_mode = 1'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        load  = 1'b0;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
